mem_cmd_scheduler: RTL and testbench

Arbitrates the shared SPI flash memory controller between two requesters: requester 0 is the UART command path, requester 1 is the pushbutton-triggered test sequencer. It owns the memory supply enable (MEM_VCC). It powers the memory up on demand, holds off commands until the power-up delay expires, and serializes one transaction at a time with round-robin fairness. After a programmable idle period it powers the memory back down. It sits in top between the requesters and the SPI memory controller.

---
 rtl/mem_cmd_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_mem_cmd_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_scheduler.sv
// mem_cmd_scheduler
//   Arbitrates the shared SPI flash controller between two requesters (0: UART
//   command path, 1: test sequencer). Owns the memory supply enable, powers the
//   flash up on demand, waits out the power-up delay, serializes one transaction
//   at a time with round-robin fairness, and powers down after an idle period.
//
// Ports
//   CLKA, rst                 clock, synchronous active-high reset
//   req[1:0]                  request levels, held until the matching grant pulse
//   op0/1, addr0/1, len0/1    per-requester command fields
//   grant/done/err[1:0]       one-hot single-cycle status pulses per requester
//   mem_vcc                   memory supply enable
//   ctrl_valid/ready          command handshake toward the SPI controller
//   ctrl_op/addr/len          latched command fields
//   ctrl_done                 end-of-transaction pulse from the SPI controller
//   busy                      high outside OFF and IDLE
module mem_cmd_scheduler #(
    parameter int unsigned POWERUP_CYCLES = 1000,
    parameter int unsigned IDLE_TIMEOUT   = 100000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic        CLKA,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [7:0]  op0,
    input  logic [7:0]  op1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [8:0]  len0,
    input  logic [8:0]  len1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        mem_vcc,
    output logic        ctrl_valid,
    input  logic        ctrl_ready,
    output logic [7:0]  ctrl_op,
    output logic [23:0] ctrl_addr,
    output logic [8:0]  ctrl_len,
    input  logic        ctrl_done,
    output logic        busy
);

    localparam logic [CNT_W-1:0] PowerupLoad = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] IdleLast    = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax      = '1;
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

    typedef enum logic [2:0] {
        StOff,
        StPowerup,
        StIdle,
        StIssue,
        StWaitDone,
        StReject
    } state_e;

    state_e      state_q;
    logic [CNT_W-1:0] cnt_q;   // power-up countdown, then idle count-up
    logic        prio_q;
    logic        owner_q;
    logic [1:0]  grant_q;
    logic [1:0]  done_q;
    logic [1:0]  err_q;
    logic        ctrl_valid_q;
    logic [7:0]  op_q;
    logic [23:0] addr_q;
    logic [8:0]  len_q;

    logic        win;
    logic [1:0]  win_onehot;
    logic [7:0]  win_op;
    logic [23:0] win_addr;
    logic [8:0]  win_len;
    logic        win_len_ok;

    // Winner selection: a lone requester wins, a tie goes to prio_q.
    always_comb begin
        win = prio_q;
        if (req == 2'b01) begin
            win = 1'b0;
        end else if (req == 2'b10) begin
            win = 1'b1;
        end
        win_onehot = {win, ~win};
        win_op     = win ? op1 : op0;
        win_addr   = win ? addr1 : addr0;
        win_len    = win ? len1 : len0;
        win_len_ok = (win_len != 9'd0) && (win_len <= 9'd256);
    end

    always_ff @(posedge CLKA) begin
        if (rst) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            grant_q      <= '0;
            done_q       <= '0;
            err_q        <= '0;
            ctrl_valid_q <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
        end else begin
            // Status outputs are single-cycle pulses unless re-armed below.
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            unique case (state_q)
                StOff: begin
                    if (|req) begin
                        state_q <= StPowerup;
                        cnt_q   <= PowerupLoad;
                    end
                end
                StPowerup: begin
                    // Leaves with cnt_q at zero, which seeds the idle count.
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StIdle: begin
                    if (|req) begin
                        owner_q <= win;
                        op_q    <= win_op;
                        addr_q  <= win_addr;
                        len_q   <= win_len;
                        cnt_q   <= '0;
                        grant_q <= win_onehot;
                        if (win_len_ok) begin
                            state_q      <= StIssue;
                            ctrl_valid_q <= 1'b1;
                        end else begin
                            // Rejection reports grant, done and err together.
                            state_q <= StReject;
                            done_q  <= win_onehot;
                            err_q   <= win_onehot;
                        end
                    end else if (cnt_q == IdleLast) begin
                        state_q <= StOff;
                        cnt_q   <= '0;
                    end else if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StIssue: begin
                    if (ctrl_ready) begin
                        state_q      <= StWaitDone;
                        ctrl_valid_q <= 1'b0;
                    end
                end
                StWaitDone: begin
                    if (ctrl_done) begin
                        state_q <= StIdle;
                        done_q  <= {owner_q, ~owner_q};
                        prio_q  <= ~owner_q;
                        cnt_q   <= '0;
                    end
                end
                StReject: begin
                    state_q <= StIdle;
                    prio_q  <= ~owner_q;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= StOff;
                end
            endcase
        end
    end

    // Pure decodes of registered state; no input reaches an output combinationally.
    assign mem_vcc    = (state_q != StOff);
    assign busy       = (state_q != StOff) && (state_q != StIdle);
    assign grant      = grant_q;
    assign done       = done_q;
    assign err        = err_q;
    assign ctrl_valid = ctrl_valid_q;
    assign ctrl_op    = op_q;
    assign ctrl_addr  = addr_q;
    assign ctrl_len   = len_q;

endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// Directed bench for mem_cmd_scheduler with POWERUP_CYCLES=4, IDLE_TIMEOUT=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_cmd_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  op0, op1;
    logic [23:0] addr0, addr1;
    logic [8:0]  len0, len1;
    logic [1:0]  grant, done, err;
    logic        mem_vcc, ctrl_valid, ctrl_ready, ctrl_done, busy;
    logic [7:0]  ctrl_op;
    logic [23:0] ctrl_addr;
    logic [8:0]  ctrl_len;

    int n_total = 0;
    int n_pass  = 0;

    mem_cmd_scheduler #(
        .POWERUP_CYCLES(4),
        .IDLE_TIMEOUT  (8),
        .CNT_W         (20)
    ) dut (
        .CLKA      (clk),
        .rst       (rst),
        .req       (req),
        .op0       (op0),
        .op1       (op1),
        .addr0     (addr0),
        .addr1     (addr1),
        .len0      (len0),
        .len1      (len1),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .mem_vcc   (mem_vcc),
        .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready),
        .ctrl_op   (ctrl_op),
        .ctrl_addr (ctrl_addr),
        .ctrl_len  (ctrl_len),
        .ctrl_done (ctrl_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller raises req while the DUT is OFF; grant must land exactly 6 cycles later.
    task automatic cold_start(input logic [1:0] exp_grant);
        tick();
        check("cold_vcc_rise", {31'd0, mem_vcc}, 1);
        check("cold_busy", {31'd0, busy}, 1);
        repeat (4) tick();
        check("cold_no_early_grant", {30'd0, grant}, 0);
        check("cold_no_early_valid", {31'd0, ctrl_valid}, 0);
        tick();
        check("cold_grant", {30'd0, grant}, {30'd0, exp_grant});
        check("cold_valid", {31'd0, ctrl_valid}, 1);
    endtask

    // Accept the command, then return ctrl_done; done must follow one cycle later.
    task automatic finish_xfer(input logic [1:0] hold_req, input logic [1:0] exp_done);
        req        = hold_req;
        ctrl_ready = 1'b1;
        tick();
        check("xfer_valid_drop", {31'd0, ctrl_valid}, 0);
        check("xfer_grant_one_cycle", {30'd0, grant}, 0);
        ctrl_ready = 1'b0;
        tick();
        check("xfer_no_early_done", {30'd0, done}, 0);
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        check("xfer_done", {30'd0, done}, {30'd0, exp_done});
        check("xfer_idle", {31'd0, busy}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [1:0] rr_exp [4];
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

        rst = 1'b1; req = '0; ctrl_ready = 1'b0; ctrl_done = 1'b0;
        op0 = '0; op1 = '0; addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
        tick(); tick();
        check("rst_vcc", {31'd0, mem_vcc}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_valid", {31'd0, ctrl_valid}, 0);
        check("rst_pulses", {26'd0, grant, done, err}, 0);
        check("rst_fields", {ctrl_op, ctrl_addr}, 0);
        check("rst_len", {23'd0, ctrl_len}, 0);
        rst = 1'b0;
        tick();
        check("off_stays_off", {31'd0, mem_vcc}, 0);

        // Cold start, requester 0.
        op0 = 8'h03; addr0 = 24'h000100; len0 = 9'd16; req = 2'b01;
        cold_start(2'b01);
        check("cold_op", {24'd0, ctrl_op}, 32'h03);
        check("cold_addr", {8'd0, ctrl_addr}, 32'h000100);
        check("cold_len", {23'd0, ctrl_len}, 16);
        finish_xfer(2'b00, 2'b01);

        // Idle power-down: vcc holds for 8 idle cycles, falls on the next edge.
        tick();
        check("idle_done_clear", {30'd0, done}, 0);
        repeat (6) tick();
        check("idle_vcc_hold", {31'd0, mem_vcc}, 1);
        tick();
        check("idle_vcc_fall", {31'd0, mem_vcc}, 0);

        // Second cold start, requester 1.
        op1 = 8'h0B; addr1 = 24'h123456; len1 = 9'd1; req = 2'b10;
        cold_start(2'b10);
        check("cold2_op", {24'd0, ctrl_op}, 32'h0B);
        check("cold2_addr", {8'd0, ctrl_addr}, 32'h123456);
        finish_xfer(2'b11, 2'b10);

        // Round robin with both requests held; prio is back at 0.
        op0 = 8'h02; op1 = 8'h05; len0 = 9'd4; len1 = 9'd8;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (grant == 2'b00 && n < 20) begin
                tick();
                n++;
            end
            check("rr_grant", {30'd0, grant}, {30'd0, rr_exp[i]});
            if (i > 0) check("rr_grant_after_done", n, 1);
            check("rr_op", {24'd0, ctrl_op}, rr_exp[i][0] ? 32'h02 : 32'h05);
            finish_xfer((i == 3) ? 2'b00 : 2'b11, rr_exp[i]);
        end

        // Backpressure, with the maximum legal length.
        op0 = 8'h9F; addr0 = 24'hABCDEF; len0 = 9'd256; req = 2'b01;
        tick();
        check("bp_grant", {30'd0, grant}, 2'b01);
        req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_grant_gone", {30'd0, grant}, 0);
            check("bp_valid_hold", {31'd0, ctrl_valid}, 1);
            check("bp_fields_hold", {ctrl_op, ctrl_addr}, 32'h9FABCDEF);
            check("bp_len_hold", {23'd0, ctrl_len}, 256);
        end
        finish_xfer(2'b00, 2'b01);

        // Invalid lengths from requester 1.
        len1 = 9'd0; req = 2'b10;
        tick();
        check("len0_pulses", {26'd0, grant, done, err}, 6'b101010);
        check("len0_no_valid", {31'd0, ctrl_valid}, 0);
        req = 2'b00;
        tick();
        check("len0_pulse_end", {26'd0, grant, done, err}, 0);
        check("len0_no_valid2", {31'd0, ctrl_valid}, 0);
        len1 = 9'd300; req = 2'b10;
        tick();
        check("len300_pulses", {26'd0, grant, done, err}, 6'b101010);
        check("len300_no_valid", {31'd0, ctrl_valid}, 0);
        req = 2'b00;
        tick();
        check("len300_idle", {31'd0, busy}, 0);

        // Stray ctrl_done in IDLE is ignored.
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        check("stray_done_idle", {30'd0, done}, 0);

        // Reset during WAIT_DONE.
        len0 = 9'd1; req = 2'b01;
        tick();
        check("rstmid_grant", {30'd0, grant}, 2'b01);
        req = 2'b00; ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        check("rstmid_waiting", {31'd0, busy}, 1);
        rst = 1'b1;
        tick();
        check("rstmid_vcc", {31'd0, mem_vcc}, 0);
        check("rstmid_busy", {31'd0, busy}, 0);
        check("rstmid_valid", {31'd0, ctrl_valid}, 0);
        rst = 1'b0; ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        check("rstmid_no_done", {30'd0, done}, 0);
        tick();
        check("rstmid_no_done2", {30'd0, done}, 0);
        check("rstmid_still_off", {31'd0, mem_vcc}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
